// File: rtl/dm_lsu_pkg.sv
// Shared types and constants for the dm load/store initiator.
// The optional write-verify path is enabled with DM_LSU_VERIFY_EN.
package dm_lsu_pkg;

    localparam int CNT_W     = 4;
    localparam int DM_ADDR_W = 16;
    localparam int DM_DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_CAP,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_DONE
    } state_e;

endpackage

// File: rtl/dm_lsu_wait_cnt.sv
// Loadable down-counter with zero flag; times both read wait and write pulse.
module dm_lsu_wait_cnt
    import dm_lsu_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dm_lsu.sv
// Load/store initiator driving dm with a setup/pulse/hold write strobe.
// Define DM_LSU_VERIFY_EN to read back every store and flag mismatches.
module dm_lsu
    import dm_lsu_pkg::*;
#(
    parameter int ADDR_W   = DM_ADDR_W,
    parameter int DATA_W   = DM_DATA_W,
    parameter int RD_WAIT  = 1,
    parameter int WE_PULSE = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] dm_read_addr_o,
    output logic [ADDR_W-1:0] dm_write_addr_o,
    output logic [DATA_W-1:0] dm_write_data_o,
    output logic              dm_we_o,
    input  logic [DATA_W-1:0] dm_read_data_i
);

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_PULSE - 1);

    state_e            state_q, state_d;
    logic              accept;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]  cnt_val;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
    logic [DATA_W-1:0] wr_data_q, rdata_q;
    logic              we_q;

    assign accept = req_valid_i && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (req_valid_i) state_d = req_we_i ? S_WR_SETUP : S_RD_WAIT;
            S_RD_WAIT:  if (cnt_zero) state_d = S_RD_CAP;
            S_RD_CAP:   state_d = S_DONE;
            S_WR_SETUP: state_d = S_WR_PULSE;
            S_WR_PULSE: if (cnt_zero) state_d = S_WR_HOLD;
`ifdef DM_LSU_VERIFY_EN
            S_WR_HOLD:  state_d = S_RD_WAIT;
`else
            S_WR_HOLD:  state_d = S_DONE;
`endif
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Counter is reloaded on entry to either timed state so its zero flag
    // already reflects the new interval during the first cycle there.
    always_comb begin
        cnt_load = (state_d != state_q) &&
                   ((state_d == S_RD_WAIT) || (state_d == S_WR_PULSE));
        cnt_val  = (state_d == S_WR_PULSE) ? WE_LOAD : RD_LOAD;
        cnt_dec  = (state_q == S_RD_WAIT) || (state_q == S_WR_PULSE);
    end

    dm_lsu_wait_cnt u_wait_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // dm_we comes straight from a flop so dm never sees a decode glitch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q      <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rdata_q   <= '0;
        end else begin
            we_q <= (state_d == S_WR_PULSE);
            if (accept && req_we_i) begin
                wr_addr_q <= req_addr_i;
                wr_data_q <= req_wdata_i;
            end
            if (accept && !req_we_i)
                rd_addr_q <= req_addr_i;
`ifdef DM_LSU_VERIFY_EN
            if (state_q == S_WR_HOLD)
                rd_addr_q <= wr_addr_q;
`endif
            if (state_q == S_RD_CAP)
                rdata_q <= dm_read_data_i;
        end
    end

`ifdef DM_LSU_VERIFY_EN
    logic store_q, err_q;

    // Case inequality so any X/Z readback bit is reported as a mismatch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            store_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                store_q <= req_we_i;
                err_q   <= 1'b0;
            end
            if (state_q == S_RD_CAP)
                err_q <= store_q && (dm_read_data_i !== wr_data_q);
        end
    end

    assign rsp_err_o = (state_q == S_DONE) && err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    assign req_ready_o     = (state_q == S_IDLE);
    assign rsp_valid_o     = (state_q == S_DONE);
    assign rsp_rdata_o     = rdata_q;
    assign dm_read_addr_o  = rd_addr_q;
    assign dm_write_addr_o = wr_addr_q;
    assign dm_write_data_o = wr_data_q;
    assign dm_we_o         = we_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Scoreboard bench for dm_lsu with a behavioural dm model and reference memory.
module tb_dm_lsu;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int RW = 1;
    localparam int WP = 2;
    localparam int LD_LAT = RW + 2;
`ifdef DM_LSU_VERIFY_EN
    localparam int ST_LAT = WP + RW + 4;
`else
    localparam int ST_LAT = WP + 3;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] dm_read_addr, dm_write_addr;
    logic [DW-1:0] dm_write_data, dm_read_data;
    logic          dm_we;

    dm_lsu #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RW), .WE_PULSE(WP)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_we_i        (req_we),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .rsp_valid_o     (rsp_valid),
        .rsp_rdata_o     (rsp_rdata),
        .rsp_err_o       (rsp_err),
        .dm_read_addr_o  (dm_read_addr),
        .dm_write_addr_o (dm_write_addr),
        .dm_write_data_o (dm_write_data),
        .dm_we_o         (dm_we),
        .dm_read_data_i  (dm_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            t_acc;
        int            lat;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] dm_mem  [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] last_rdata;
    bit            stuck0 = 1'b0;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return {16'hA5A5, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // dm model: edge-triggered write strobe, read data settled mid-cycle
    always @(posedge dm_we)
        dm_mem[dm_write_addr] = stuck0 ? (dm_write_data & ~32'h1) : dm_write_data;

    always @(negedge clk)
        dm_read_data <= dm_mem.exists(dm_read_addr) ? dm_mem[dm_read_addr] : dflt(dm_read_addr);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_rsp: rsp_valid with no request outstanding (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", rsp_err, e.err);
                chk("latency", cyc - e.t_acc, e.lat);
            end
        end
    end

    task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit hold);
        exp_t e;
        int waited = 0;
        logic [DW-1:0] rb;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            chk("accept_timeout", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        e.t_acc = cyc;
        e.err   = 1'b0;
        if (we) begin
            rb = stuck0 ? (d & ~32'h1) : d;
            ref_mem[a] = rb;
`ifdef DM_LSU_VERIFY_EN
            last_rdata = rb;
            e.err = (rb != d);
`endif
            e.rdata = last_rdata;
            e.lat   = ST_LAT;
        end else begin
            last_rdata = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
            e.rdata = last_rdata;
            e.lat   = LD_LAT;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) begin
            req_valid = 1'b0;
            req_we    = 1'($urandom);
            req_addr  = AW'($urandom);
            req_wdata = $urandom;
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        req_valid = 1'b0;
        while ((sb.size() != 0 || !req_ready) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d responses missing", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [AW-1:0] alist [6];
        logic [AW-1:0] a;
        bit we, hold;
        alist = '{16'h0000, 16'h0001, 16'h0003, 16'h0010, 16'hFFFF, 16'h7FFE};
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        last_rdata = '0;
        dm_mem[16'h0003]  = 32'hDEADBEEF;
        ref_mem[16'h0003] = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_dm_we", dm_we, 0);
        chk("rst_read_addr", dm_read_addr, 0);
        chk("rst_write_addr", dm_write_addr, 0);
        chk("rst_write_data", dm_write_data, 0);
        rst = 1'b0;

        // load 0x0003: busy for exactly the load latency
        issue(1'b0, 16'h0003, 32'h0, 1'b0);
        for (int k = 1; k <= LD_LAT; k++) begin
            @(negedge clk);
            chk("ready_busy", req_ready, 0);
        end
        @(negedge clk);
        chk("ready_after", req_ready, 1);

        // store with setup/pulse/hold waveform check, then read back
        issue(1'b1, 16'h0010, 32'h12345678, 1'b0);
        for (int k = 1; k <= WP + 2; k++) begin
            @(negedge clk);
            chk("dm_we_shape", dm_we, ((k >= 2) && (k <= WP + 1)) ? 1 : 0);
            chk("wr_addr_stable", dm_write_addr, 16'h0010);
            chk("wr_data_stable", dm_write_data, 32'h12345678);
        end
        issue(1'b0, 16'h0010, 32'h0, 1'b0);
        wait_idle();

        // req_valid held high, alternating store/load at the top address
        for (int i = 0; i < 6; i++)
            issue((i % 2) == 0, 16'hFFFF, $urandom, 1'b1);
        wait_idle();

        // reset while dm_we is high aborts the store without a response
        issue(1'b1, 16'h0020, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("pulse_before_rst", dm_we, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        void'(sb.pop_back());
        last_rdata = '0;
        @(negedge clk);
        chk("abort_dm_we", dm_we, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        issue(1'b0, 16'h0020, 32'h0, 1'b0);
        wait_idle();

`ifdef DM_LSU_VERIFY_EN
        stuck0 = 1'b1;
        issue(1'b1, 16'h0030, 32'h00000001, 1'b0);
        issue(1'b1, 16'h0031, 32'h00000002, 1'b0);
        wait_idle();
        stuck0 = 1'b0;
`endif

        // randomized mix over a small address pool
        for (int i = 0; i < 40; i++) begin
            a    = ($urandom_range(0, 7) == 0) ? AW'($urandom) : alist[$urandom_range(0, 5)];
            we   = 1'($urandom);
            hold = 1'($urandom);
            issue(we, a, $urandom, hold);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_lsu.md
Name: dm_lsu

Overview:
- Load/store initiator between the sisc execute stage and the data memory (dm).
- Accepts one word request at a time over a valid/ready handshake and drives dm's read_addr, write_addr, write_data and dm_we.
- dm writes on the rising edge of dm_we, so this block produces a clean setup, pulse, hold sequence for every write.
- Samples dm read_data after a programmable number of wait cycles and returns it as a single-cycle response.

Parameters:
- ADDR_W, 16, word address width (matches dm).
- DATA_W, 32, data word width.
- RD_WAIT, 1, cycles dm_read_addr is held before read_data is captured; legal range 1..15.
- WE_PULSE, 1, cycles dm_we is held high per write; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  load data (see Behaviour for stores).
- rsp_err  out  1  write-verify mismatch; 0 unless DM_LSU_VERIFY_EN.
- dm_read_addr  out  ADDR_W  to dm read_addr.
- dm_write_addr  out  ADDR_W  to dm write_addr.
- dm_write_data  out  DATA_W  to dm write_data.
- dm_we  out  1  to dm dm_we (edge-triggered write strobe).
- dm_read_data  in  DATA_W  from dm read_data.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs and registers are 0, except req_ready, which is 1.
  - The wait counter is cleared.
  - Reset mid-write drops dm_we low at the reset edge. A rising edge already issued is not undone, so the memory may already hold the new word. No response is produced for the aborted request.
- Handshake:
  - Accept occurs when req_valid && req_ready on a clk edge (cycle T). req_ready = (state == IDLE).
  - req_we, req_addr and req_wdata are registered at accept and ignored afterwards.
  - There is no rsp backpressure: rsp_valid is exactly one cycle.
- States: IDLE, RD_WAIT, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- Load sequence:
  - IDLE -> RD_WAIT. dm_read_addr is driven with the registered address from T+1 and held through RD_CAP.
  - The counter counts RD_WAIT cycles (T+1..T+RD_WAIT), then RD_CAP at T+RD_WAIT+1 registers dm_read_data into rsp_rdata.
  - DONE at T+RD_WAIT+2 asserts rsp_valid. Load latency is RD_WAIT+2.
- Store sequence:
  - WR_SETUP at T+1: dm_write_addr and dm_write_data are valid, dm_we=0.
  - WR_PULSE for T+2..T+1+WE_PULSE: dm_we=1.
  - WR_HOLD at T+2+WE_PULSE: dm_we=0, address and data unchanged.
  - DONE at T+3+WE_PULSE: rsp_valid=1. Store latency is WE_PULSE+3.
  - rsp_rdata keeps its previous value on stores.
- Output hold: dm_write_addr and dm_write_data hold their last values outside store sequences. dm_read_addr holds its last value outside loads.
- Registering: dm_we is driven from a register, never decoded combinationally, so it is glitch-free.
- DONE -> IDLE always. A new request is accepted earliest the cycle after DONE, so back-to-back loads have a period of RD_WAIT+3.
- Counter: width 4, loaded with parameter-1 on state entry and decremented to 0. No wrap is possible.
- Address range: addresses are passed unmodified; 0xFFFF is legal.
- Undefined data: dm_read_data may be X for unloaded addresses. rsp_rdata propagates it unchanged.

Optional Feature:
- Macro: DM_LSU_VERIFY_EN.
- Defined:
  - WR_HOLD -> RD_WAIT with dm_read_addr = write address, then RD_CAP and DONE.
  - rsp_rdata = readback value.
  - rsp_err = (readback != stored wdata) on the DONE cycle; any X or Z bit counts as a mismatch.
  - Store latency becomes WE_PULSE+RD_WAIT+4.
- Undefined: rsp_err is tied 0 and the store path is as above.

Decomposition:
- Package dm_lsu_pkg holds:
  - the state enum typedef;
  - the CNT_W=4 constant;
  - the default ADDR_W and DATA_W localparams shared with dm.
- One natural sub-module, dm_lsu_wait_cnt: a loadable 4-bit down-counter with a zero flag, used for both the RD_WAIT and WE_PULSE timing.

Test Plan:
- Reset then load with RD_WAIT=1, addr 0x0003, dm model holds 0xDEADBEEF -> rsp_valid exactly 3 cycles after accept, rsp_rdata=0xDEADBEEF, req_ready low for 3 cycles.
- Store with WE_PULSE=2, addr 0x0010, data 0x12345678 -> dm_we low at T+1, high at T+2..T+3, low at T+4; address and data stable T+1..T+4; rsp_valid at T+5; a following load of 0x0010 returns 0x12345678.
- req_valid held high with alternating store and load at 0xFFFF -> each accepted only when req_ready=1, no request dropped, readback equals the written value.
- rst asserted during WR_PULSE -> dm_we=0 and req_ready=1 the next cycle; no rsp_valid; the next load completes normally.
- DM_LSU_VERIFY_EN with a dm model that forces bit 0 stuck at 0, store 0x00000001 -> rsp_rdata=0x00000000, rsp_err=1; store 0x00000002 -> rsp_err=0.
